ttl_74502: RTL and testbench
============================

Name: ttl_74502

Overview:
- Successive-approximation register (SAR), 74LS502 style, parameterised width.
- Sits directly downstream of the ttl_7485 magnitude comparator and closes the loop with it.
- Q drives the comparator B input. The sample under conversion drives A.
- The comparator's "A >= B" result (AGreater_out | Equal_out) returns as D.
- After WIDTH decisions Q equals the sample, and Complete_bar flags the result valid.

Parameters:
WIDTH, 8, bits in the approximation word (>= 2)
DELAY_RISE, 0, output rise delay applied to every output
DELAY_FALL, 0, output fall delay applied to every output

Ports:
Clk  input  1  clock; all state changes on rising edge
Clear_bar  input  1  asynchronous active-low reset
Start_bar  input  1  synchronous active-low conversion start, sampled on Clk rise
D  input  1  comparator decision: 1 = keep the trial bit, 0 = drop it
Q  output  WIDTH  approximation / result word
Serial_out  output  1  registered copy of the last decision bit (MSB-first result stream)
Complete_bar  output  1  low = conversion finished and Q valid; high = converting or idle after reset

Behaviour:
- Reset (Clear_bar low, no clock needed): Q=0, Serial_out=0, Complete_bar=1, state IDLE, bit pointer cleared. Reset mid-conversion aborts it completely. Outputs stay held while Clear_bar is low.
- States:
  - IDLE: after reset.
  - CONVERT: bit pointer p from WIDTH-1 down to 0.
  - DONE.
- Start edge (Start_bar low at Clk rise, any state):
  - Q = 1 followed by WIDTH-1 zeros.
  - p = WIDTH-1, Complete_bar=1, next state CONVERT.
  - Start has priority over everything except Clear_bar, so a start mid-conversion restarts.
  - Start_bar held low continuously re-initialises on every edge.
- CONVERT edge (Start_bar high):
  - Q[p] = D and Serial_out = D.
  - If p > 0: Q[p-1] = 1 and p decrements. Bits below p-1 stay 0; bits above p are unchanged.
  - If p == 0: state DONE and Complete_bar = 0 on this same edge.
- Latency: Complete_bar falls on the WIDTH-th rising edge after the start edge.
- DONE and IDLE edges (Start_bar high): Q, Serial_out and Complete_bar are held. D is ignored.
- D is only sampled in CONVERT. An X on D outside CONVERT must not propagate.
- All outputs are registered values passed through #(DELAY_RISE, DELAY_FALL) continuous assigns.

Decomposition:
- No shared package needed. Constants (state encoding, pointer width = clog2(WIDTH)) are localparams in the module.
- The pointer may be a one-hot shift register internally instead of a counter. No sub-module is warranted.
- The bench instantiates ttl_7485 (chained for WIDTH > 4) as the comparator model in the loop.

Test Plan:
- Reset: drive Clear_bar low mid-conversion (after the 3rd decision edge) -> immediately Q=0x00, Complete_bar=1, Serial_out=0. After release, Start_bar high clocks keep Q=0x00.
- Closed loop, WIDTH=8, A=0xB3, D=(A>=Q):
  - Q after start and each edge: 80,C0,A0,B0,B8,B4,B2,B3,B3.
  - Serial_out stream: 1,0,1,1,0,0,1,1.
  - Complete_bar low exactly on the 8th edge after start.
- Extremes: D tied 0 -> final Q=0x00; D tied 1 -> final Q=0xFF. Complete_bar low at edge 8 in both cases.
- Restart: Start_bar low again at the 4th decision edge -> Q=0x80, Complete_bar=1. The new conversion completes 8 edges later with the correct result for the new A.
- Hold: after DONE, 10 edges with Start_bar high and D toggling -> Q, Serial_out, Complete_bar unchanged.
- WIDTH=4 instance, single ttl_7485 in loop, A=0x9 -> Q trace 8,C,A,9,9 and Complete_bar low on the 4th edge.

Source files
------------

// File: rtl/ttl_7485.sv
// ttl_7485: 4-bit magnitude comparator with cascade inputs (low-order stage feeds the high-order one).
module ttl_7485 (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       ALess_in,
    input  logic       Equal_in,
    input  logic       AGreater_in,
    output logic       ALess_out,
    output logic       Equal_out,
    output logic       AGreater_out
);
    logic eq;
    assign eq           = A == B;
    assign AGreater_out = (A > B) | (eq & AGreater_in);
    assign ALess_out    = (A < B) | (eq & ALess_in);
    assign Equal_out    = eq & Equal_in;
endmodule

// File: rtl/ttl_74502.sv
// ttl_74502: 74LS502-style successive-approximation register.
// Bit pointer is a one-hot mask walking from the MSB down to bit 0.
module ttl_74502 #(
    parameter int WIDTH      = 8,
    parameter int DELAY_RISE = 0,
    parameter int DELAY_FALL = 0
) (
    input  logic             Clk,
    input  logic             Clear_bar,
    input  logic             Start_bar,
    input  logic             D,
    output logic [WIDTH-1:0] Q,
    output logic             Serial_out,
    output logic             Complete_bar
);
    typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_t;
    localparam logic [WIDTH-1:0] MSB = {1'b1, {(WIDTH-1){1'b0}}};
    state_t state, state_n;
    logic [WIDTH-1:0] q_r, q_n, p_r, p_n;
    logic ser_r, ser_n, cb_r, cb_n;
    always_ff @(posedge Clk or negedge Clear_bar)
        if (!Clear_bar) begin
            state <= IDLE;
            q_r   <= '0;
            p_r   <= '0;
            ser_r <= 1'b0;
            cb_r  <= 1'b1;
        end else begin
            state <= state_n;
            q_r   <= q_n;
            p_r   <= p_n;
            ser_r <= ser_n;
            cb_r  <= cb_n;
        end
    // D is only looked at in CONVERT, so an unknown decision elsewhere never reaches state
    always_comb begin
        state_n = state;
        q_n     = q_r;
        p_n     = p_r;
        ser_n   = ser_r;
        cb_n    = cb_r;
        if (!Start_bar) begin
            state_n = CONVERT;
            q_n     = MSB;
            p_n     = MSB;
            cb_n    = 1'b1;
        end else if (state == CONVERT) begin
            q_n   = (q_r & ~p_r) | (D ? p_r : '0) | (p_r >> 1);
            ser_n = D;
            p_n   = p_r >> 1;
            state_n = p_r[0] ? DONE : CONVERT;
            cb_n    = ~p_r[0];
        end
    end
    assign #(DELAY_RISE, DELAY_FALL) Q            = q_r;
    assign #(DELAY_RISE, DELAY_FALL) Serial_out   = ser_r;
    assign #(DELAY_RISE, DELAY_FALL) Complete_bar = cb_r;
endmodule

// File: tb/tb_ttl_74502.sv
// tb_ttl_74502: closed-loop SAR + 7485 bench, table-driven vectors plus reset/hold sequences.
module tb_ttl_74502;
    typedef struct {
        logic       w4;
        logic       st_n;
        logic [7:0] a;
        logic [2:0] dm;
        logic [7:0] q;
        logic       ser;
        logic       cb;
    } vec_t;
    logic clk = 1'b0, clear_bar = 1'b0, st8 = 1'b1, st4 = 1'b1, tog = 1'b0;
    logic [7:0] a = 8'h00;
    logic [2:0] dm = 3'd0;
    logic [7:0] q8;
    logic [3:0] q4;
    logic ser8, cb8, ser4, cb4, d8, d4;
    logic lt_l, eq_l, gt_l, lt_h, eq_h, gt_h, lt_4, eq_4, gt_4;
    int n_vec = 0, n_bad = 0;
    vec_t vq[$];
    always #5 clk = ~clk;
    ttl_7485 cmp_lo (.A(a[3:0]), .B(q8[3:0]), .ALess_in(1'b0), .Equal_in(1'b1), .AGreater_in(1'b0),
                     .ALess_out(lt_l), .Equal_out(eq_l), .AGreater_out(gt_l));
    ttl_7485 cmp_hi (.A(a[7:4]), .B(q8[7:4]), .ALess_in(lt_l), .Equal_in(eq_l), .AGreater_in(gt_l),
                     .ALess_out(lt_h), .Equal_out(eq_h), .AGreater_out(gt_h));
    ttl_7485 cmp_4 (.A(a[3:0]), .B(q4), .ALess_in(1'b0), .Equal_in(1'b1), .AGreater_in(1'b0),
                    .ALess_out(lt_4), .Equal_out(eq_4), .AGreater_out(gt_4));
    // dm: 0 = comparator loop, 1 = tied low, 2 = tied high, 3 = toggling, 4 = unknown
    function automatic logic dsel(input logic ge);
        return dm == 3'd0 ? ge : dm == 3'd1 ? 1'b0 : dm == 3'd2 ? 1'b1 : dm == 3'd3 ? tog : 1'bx;
    endfunction
    assign d8 = dsel(gt_h | eq_h);
    assign d4 = dsel(gt_4 | eq_4);
    ttl_74502 #(.WIDTH(8)) dut8 (.Clk(clk), .Clear_bar(clear_bar), .Start_bar(st8), .D(d8),
                                 .Q(q8), .Serial_out(ser8), .Complete_bar(cb8));
    ttl_74502 #(.WIDTH(4)) dut4 (.Clk(clk), .Clear_bar(clear_bar), .Start_bar(st4), .D(d4),
                                 .Q(q4), .Serial_out(ser4), .Complete_bar(cb4));
    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask
    task automatic chk8(input string nm, input logic [7:0] q, input logic ser, input logic cb);
        chk({nm, " Q"}, q8, q);
        chk({nm, " Serial_out"}, {7'd0, ser8}, {7'd0, ser});
        chk({nm, " Complete_bar"}, {7'd0, cb8}, {7'd0, cb});
    endtask
    task automatic add(input logic w4, input logic st_n, input logic [7:0] av, input logic [2:0] m,
                       input logic [7:0] q, input logic ser, input logic cb);
        vec_t v;
        v = '{w4: w4, st_n: st_n, a: av, dm: m, q: q, ser: ser, cb: cb};
        vq.push_back(v);
    endtask
    task automatic add_seq(input logic [7:0] av, input logic [2:0] m, input logic ser0,
                           input logic [7:0] qs[8], input logic [7:0] ss);
        add(1'b0, 1'b0, av, m, 8'h80, ser0, 1'b1);
        for (int i = 0; i < 8; i++) add(1'b0, 1'b1, av, m, qs[i], ss[7-i], i != 7);
    endtask
    initial begin
        logic [7:0] qs[8];
        // reset state with Clear_bar low from time zero
        @(negedge clk);
        chk8("reset", 8'h00, 1'b0, 1'b1);
        chk("reset Q4", {4'd0, q4}, 8'h00);
        clear_bar = 1'b1;
        // abort mid-conversion: start + 3 decisions, then async clear
        a = 8'hB3; st8 = 1'b0;
        @(posedge clk); @(negedge clk);
        chk8("pre-abort start", 8'h80, 1'b0, 1'b1);
        st8 = 1'b1;
        repeat (3) begin @(posedge clk); @(negedge clk); end
        chk8("pre-abort edge3", 8'hB0, 1'b1, 1'b1);
        #2 clear_bar = 1'b0;
        #1 chk8("async clear", 8'h00, 1'b0, 1'b1);
        st8 = 1'b0;
        @(posedge clk); @(negedge clk);
        chk8("clear held", 8'h00, 1'b0, 1'b1);
        clear_bar = 1'b1; st8 = 1'b1;
        repeat (2) begin @(posedge clk); @(negedge clk); end
        chk8("idle after clear", 8'h00, 1'b0, 1'b1);
        // closed loop A=B3
        qs = '{8'hC0, 8'hA0, 8'hB0, 8'hB8, 8'hB4, 8'hB2, 8'hB3, 8'hB3};
        add_seq(8'hB3, 3'd0, 1'b0, qs, 8'b1011_0011);
        // D tied low then high
        qs = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h00};
        add_seq(8'h00, 3'd1, 1'b1, qs, 8'h00);
        add(1'b0, 1'b0, 8'h00, 3'd2, 8'h80, 1'b0, 1'b1);
        qs = '{8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF, 8'hFF};
        add_seq(8'h00, 3'd2, 1'b0, qs, 8'hFF);
        // restart at the 4th decision edge: A=5A abandoned, A=3C converted
        add(1'b0, 1'b0, 8'h5A, 3'd0, 8'h80, 1'b1, 1'b1);
        add(1'b0, 1'b1, 8'h5A, 3'd0, 8'h40, 1'b0, 1'b1);
        add(1'b0, 1'b1, 8'h5A, 3'd0, 8'h60, 1'b1, 1'b1);
        add(1'b0, 1'b1, 8'h5A, 3'd0, 8'h50, 1'b0, 1'b1);
        qs = '{8'h40, 8'h20, 8'h30, 8'h38, 8'h3C, 8'h3E, 8'h3D, 8'h3C};
        add_seq(8'h3C, 3'd0, 1'b0, qs, 8'b0011_1100);
        // WIDTH=4 loop, A=9
        add(1'b1, 1'b0, 8'h09, 3'd0, 8'h08, 1'b0, 1'b1);
        add(1'b1, 1'b1, 8'h09, 3'd0, 8'h0C, 1'b1, 1'b1);
        add(1'b1, 1'b1, 8'h09, 3'd0, 8'h0A, 1'b0, 1'b1);
        add(1'b1, 1'b1, 8'h09, 3'd0, 8'h09, 1'b0, 1'b1);
        add(1'b1, 1'b1, 8'h09, 3'd0, 8'h09, 1'b1, 1'b0);
        foreach (vq[i]) begin
            a = vq[i].a; dm = vq[i].dm;
            st8 = vq[i].w4 | vq[i].st_n;
            st4 = ~vq[i].w4 | vq[i].st_n;
            @(posedge clk); @(negedge clk);
            if (vq[i].w4) begin
                chk($sformatf("v%0d Q4", i), {4'd0, q4}, vq[i].q);
                chk($sformatf("v%0d Serial_out4", i), {7'd0, ser4}, {7'd0, vq[i].ser});
                chk($sformatf("v%0d Complete_bar4", i), {7'd0, cb4}, {7'd0, vq[i].cb});
            end else
                chk8($sformatf("v%0d", i), vq[i].q, vq[i].ser, vq[i].cb);
        end
        // hold in DONE with toggling and unknown D
        st8 = 1'b1; st4 = 1'b1; a = 8'h00;
        for (int i = 0; i < 10; i++) begin
            dm = (i % 3 == 2) ? 3'd4 : 3'd3;
            tog = i[0];
            @(posedge clk); @(negedge clk);
            chk8($sformatf("hold%0d", i), 8'h3C, 1'b0, 1'b0);
        end
        chk("hold Q4", {4'd0, q4}, 8'h09);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
